// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: pipeline write-back, long-unit handshake,
// register-file write port, stall request and hazard query.
interface wb_port_arbiter_if;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd;
    logic        stall_wb;
    logic [4:0]  chk_rd;
    logic        chk_busy;
    logic [1:0]  fifo_count;

    // pipeline / long unit / hazard-query side
    modport master (
        output reg_write_w, rd_w, result_w, lu_valid, lu_rd, lu_data, chk_rd,
        input  lu_ready, rf_we, rf_addr, rf_wd, stall_wb, chk_busy, fifo_count
    );

    // arbiter side
    modport slave (
        input  reg_write_w, rd_w, result_w, lu_valid, lu_rd, lu_data, chk_rd,
        output lu_ready, rf_we, rf_addr, rf_wd, stall_wb, chk_busy, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline
// write-back stage and a long-latency unit (mul/div).  Long-unit results
// wait in a 2-entry in-order FIFO; the pipeline has priority, but a head
// entry blocked for STARVE_LIMIT cycles forces a one-cycle write-back stall.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    // Counter never holds STARVE_LIMIT itself: reaching it clears the
    // counter and arms the stall on the same edge.
    localparam logic [3:0] LP_STARVE_LAST = 4'(STARVE_LIMIT - 1);

    logic [4:0]  r_rd   [2];
    logic [31:0] r_data [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic [3:0]  r_starve;
    logic        r_stall;

    logic        w_fifo_ne;
    logic        w_pipe_act;
    logic        w_use_pipe;
    logic        w_deq;
    logic        w_blocked;
    logic        w_acc;
    logic        w_enq;
    logic        w_tail;
    logic        w_starve_hit;
    logic [1:0]  w_slot_vld;

    assign w_fifo_ne    = (r_count != 2'd0);
    assign w_pipe_act   = bus.reg_write_w && (bus.rd_w != 5'd0);
    assign w_use_pipe   = w_pipe_act && !r_stall;
    assign w_deq        = w_fifo_ne && !w_use_pipe;
    assign w_blocked    = w_fifo_ne && w_use_pipe;
    // Deliberately not looking at w_deq: a full FIFO refuses even when
    // it is draining this cycle.
    assign bus.lu_ready = (r_count < 2'd2);
    assign w_acc        = bus.lu_valid && bus.lu_ready;
    assign w_enq        = w_acc && (bus.lu_rd != 5'd0);
    // With count 0 the tail is the head slot, with count 1 the other slot.
    assign w_tail       = r_head ^ r_count[0];
    assign w_starve_hit = w_blocked && (r_starve == LP_STARVE_LAST);

    assign bus.stall_wb   = r_stall;
    assign bus.fifo_count = r_count;

    // Register-file port mux: pipeline first, else FIFO head, else zeros.
    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_addr = 5'd0;
        bus.rf_wd   = 32'd0;
        if (w_use_pipe) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = bus.rd_w;
            bus.rf_wd   = bus.result_w;
        end else if (w_fifo_ne) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = r_rd[r_head];
            bus.rf_wd   = r_data[r_head];
        end
    end

    // Hazard query against every occupied FIFO slot.
    always_comb begin
        w_slot_vld[0] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b0));
        w_slot_vld[1] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b1));
        bus.chk_busy  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (w_slot_vld[i] && (r_rd[i] == bus.chk_rd) && (bus.chk_rd != 5'd0)) begin
                bus.chk_busy = 1'b1;
            end
        end
    end

    // FIFO payload storage; occupancy tracking makes stale slots harmless.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rd[w_tail]   <= bus.lu_rd;
            r_data[w_tail] <= bus.lu_data;
        end
    end

    // FIFO head pointer and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    // Starvation counter and the one-cycle write-back stall it triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
            r_stall  <= 1'b0;
        end else begin
            r_stall <= w_starve_hit;
            if (!w_blocked || w_starve_hit) begin
                r_starve <= 4'd0;
            end else begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_wb_port_arbiter;
    localparam int LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input logic w, input logic [4:0] rd, input logic [31:0] d);
        bus.reg_write_w = w;
        bus.rd_w        = rd;
        bus.result_w    = d;
    endtask

    task automatic setl(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = v;
        bus.lu_rd    = rd;
        bus.lu_data  = d;
    endtask

    // Reference model: pending long-unit results as a plain queue.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_starve = 0;
    bit   m_stall  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            begin
                logic        pipe;
                logic        e_we;
                logic [4:0]  e_addr;
                logic [31:0] e_wd;
                bit          pop;
                bit          busy;
                int          n;
                ent_t        e;
                if (!rst_n) begin
                    mq.delete();
                    m_starve = 0;
                    m_stall  = 1'b0;
                end
                n      = mq.size();
                pipe   = bus.reg_write_w && (bus.rd_w != 5'd0);
                pop    = 1'b0;
                e_we   = 1'b0;
                e_addr = 5'd0;
                e_wd   = 32'd0;
                if (pipe && !m_stall) begin
                    e_we   = 1'b1;
                    e_addr = bus.rd_w;
                    e_wd   = bus.result_w;
                end else if (n > 0) begin
                    e_we   = 1'b1;
                    e_addr = mq[0].rd;
                    e_wd   = mq[0].data;
                    pop    = 1'b1;
                end
                busy = 1'b0;
                if (bus.chk_rd != 5'd0) begin
                    foreach (mq[i]) if (mq[i].rd == bus.chk_rd) busy = 1'b1;
                end
                chk("m_rf_we",      32'(bus.rf_we),      32'(e_we));
                chk("m_rf_addr",    32'(bus.rf_addr),    32'(e_addr));
                chk("m_rf_wd",      bus.rf_wd,           e_wd);
                chk("m_fifo_count", 32'(bus.fifo_count), n);
                chk("m_lu_ready",   32'(bus.lu_ready),   (n < 2) ? 1 : 0);
                chk("m_stall_wb",   32'(bus.stall_wb),   32'(m_stall));
                chk("m_chk_busy",   32'(bus.chk_busy),   32'(busy));
                if (rst_n) begin
                    if (n > 0 && !pop) begin
                        m_starve++;
                        m_stall = (m_starve == LIMIT);
                        if (m_stall) m_starve = 0;
                    end else begin
                        m_starve = 0;
                        m_stall  = 1'b0;
                    end
                    if (pop) void'(mq.pop_front());
                    if (bus.lu_valid && (n < 2) && (bus.lu_rd != 5'd0)) begin
                        e.rd   = bus.lu_rd;
                        e.data = bus.lu_data;
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        setp(1'b1, 5'd5, 32'h1234);
        setl(1'b0, 5'd0, 32'd0);
        bus.chk_rd = 5'd3;
        cyc();
        cyc();
        // during reset: empty FIFO, pipeline still reaches the port
        chk("rst_fifo_count", 32'(bus.fifo_count), 0);
        chk("rst_lu_ready",   32'(bus.lu_ready),   1);
        chk("rst_stall_wb",   32'(bus.stall_wb),   0);
        chk("rst_chk_busy",   32'(bus.chk_busy),   0);
        chk("rst_rf_we",      32'(bus.rf_we),      1);
        chk("rst_rf_addr",    32'(bus.rf_addr),    5);
        rst_n = 1'b1;

        // pipeline-only writes, including rd 0
        setp(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("pipe_rf_we",   32'(bus.rf_we),   1);
        chk("pipe_rf_addr", 32'(bus.rf_addr), 5);
        chk("pipe_rf_wd",   bus.rf_wd,        32'hDEADBEEF);
        setp(1'b1, 5'd0, 32'hFFFF);
        #1;
        chk("x0_rf_we",   32'(bus.rf_we),   0);
        chk("x0_rf_addr", 32'(bus.rf_addr), 0);
        chk("x0_rf_wd",   bus.rf_wd,        0);
        cyc();

        // single long-unit result on an idle pipeline
        setp(1'b0, 5'd0, 32'd0);
        setl(1'b1, 5'd7, 32'h12);
        #1;
        chk("lu1_ready",      32'(bus.lu_ready),   1);
        chk("lu1_no_bypass",  32'(bus.rf_we),      0);
        cyc();
        setl(1'b0, 5'd0, 32'd0);
        bus.chk_rd = 5'd7;
        #1;
        chk("lu1_count",   32'(bus.fifo_count), 1);
        chk("lu1_rf_we",   32'(bus.rf_we),      1);
        chk("lu1_rf_addr", 32'(bus.rf_addr),    7);
        chk("lu1_rf_wd",   bus.rf_wd,           32'h12);
        chk("lu1_busy",    32'(bus.chk_busy),   1);
        cyc();
        chk("lu1_drained", 32'(bus.fifo_count), 0);
        chk("lu1_idle_we", 32'(bus.rf_we),      0);
        chk("lu1_busy0",   32'(bus.chk_busy),   0);

        // fill under constant pipeline traffic, then starvation stall
        setp(1'b1, 5'd1, 32'hAAAA0001);
        setl(1'b1, 5'd9, 32'h99);
        cyc();
        setl(1'b1, 5'd10, 32'hA0);
        #1;
        chk("blk_count1",  32'(bus.fifo_count), 1);
        chk("blk_addr1",   32'(bus.rf_addr),    1);
        cyc();
        setl(1'b1, 5'd11, 32'hB0);
        bus.chk_rd = 5'd9;
        #1;
        chk("full_count",   32'(bus.fifo_count), 2);
        chk("full_ready",   32'(bus.lu_ready),   0);
        chk("full_stall",   32'(bus.stall_wb),   0);
        chk("full_busy9",   32'(bus.chk_busy),   1);
        bus.chk_rd = 5'd11;
        #1;
        chk("full_busy11",  32'(bus.chk_busy),   0);
        bus.chk_rd = 5'd10;
        #1;
        chk("full_busy10",  32'(bus.chk_busy),   1);
        cyc();
        chk("blk3_stall",   32'(bus.stall_wb),   0);
        chk("blk3_count",   32'(bus.fifo_count), 2);
        cyc();
        chk("blk4_stall",   32'(bus.stall_wb),   0);
        cyc();
        chk("stv_stall",    32'(bus.stall_wb),   1);
        chk("stv_rf_addr",  32'(bus.rf_addr),    9);
        chk("stv_rf_wd",    bus.rf_wd,           32'h99);
        chk("stv_ready",    32'(bus.lu_ready),   0);
        cyc();
        chk("post_stall",   32'(bus.stall_wb),   0);
        chk("post_count",   32'(bus.fifo_count), 1);
        chk("post_rf_addr", 32'(bus.rf_addr),    1);
        chk("post_rf_wd",   bus.rf_wd,           32'hAAAA0001);
        chk("post_ready",   32'(bus.lu_ready),   1);
        cyc();

        // drain in order, with a simultaneous enqueue/dequeue at count 1
        setp(1'b0, 5'd0, 32'd0);
        setl(1'b0, 5'd0, 32'd0);
        #1;
        chk("drn_count2",  32'(bus.fifo_count), 2);
        chk("drn_addr10",  32'(bus.rf_addr),    10);
        chk("drn_wd10",    bus.rf_wd,           32'hA0);
        cyc();
        setl(1'b1, 5'd12, 32'hC0);
        #1;
        chk("sim_count1",  32'(bus.fifo_count), 1);
        chk("sim_addr11",  32'(bus.rf_addr),    11);
        chk("sim_wd11",    bus.rf_wd,           32'hB0);
        cyc();
        setl(1'b0, 5'd0, 32'd0);
        #1;
        chk("sim_count",   32'(bus.fifo_count), 1);
        chk("sim_addr12",  32'(bus.rf_addr),    12);
        chk("sim_wd12",    bus.rf_wd,           32'hC0);
        cyc();
        chk("sim_empty",   32'(bus.fifo_count), 0);

        // rd_w == 0 is no pipeline write, so the FIFO drains under it
        setl(1'b1, 5'd3, 32'h33);
        cyc();
        setl(1'b0, 5'd0, 32'd0);
        setp(1'b1, 5'd0, 32'h77);
        #1;
        chk("x0fifo_addr", 32'(bus.rf_addr), 3);
        chk("x0fifo_wd",   bus.rf_wd,        32'h33);
        cyc();

        // reset pulse with a full FIFO discards both entries
        setp(1'b1, 5'd2, 32'h2222);
        setl(1'b1, 5'd13, 32'hD0);
        cyc();
        setl(1'b1, 5'd14, 32'hE0);
        cyc();
        setl(1'b0, 5'd0, 32'd0);
        bus.chk_rd = 5'd13;
        #1;
        chk("prerst_count", 32'(bus.fifo_count), 2);
        chk("prerst_busy",  32'(bus.chk_busy),   1);
        rst_n = 1'b0;
        setp(1'b0, 5'd0, 32'd0);
        #1;
        chk("rstm_count",  32'(bus.fifo_count), 0);
        chk("rstm_ready",  32'(bus.lu_ready),   1);
        chk("rstm_rf_we",  32'(bus.rf_we),      0);
        chk("rstm_busy",   32'(bus.chk_busy),   0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("aft_rst_we",  32'(bus.rf_we),      0);
        cyc();
        chk("aft_rst_we2", 32'(bus.rf_we),      0);

        // long-unit result for x0: handshake only, nothing buffered
        setl(1'b1, 5'd0, 32'h55);
        #1;
        chk("lu0_ready", 32'(bus.lu_ready), 1);
        cyc();
        setl(1'b0, 5'd0, 32'd0);
        #1;
        chk("lu0_count", 32'(bus.fifo_count), 0);
        chk("lu0_rf_we", 32'(bus.rf_we),      0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
